// File: rtl/serdes_frame_rx.sv
// serdes_frame_rx: framed serial receiver for the SerDes link.
// Samples ser_in on ser_en strobes, recognises start-bit framed bytes
// (LSB first), checks the optional even parity bit and the stop bit, and
// holds each good byte on data_out until the consumer reads it.
// Optional feature macro: SERDES_RX_PARITY_EN (adds the parity bit, 11-bit
// frame). Without it the frame is 10 bits and parity_err is always 0.
module serdes_frame_rx #(
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_en,
    input  logic       ser_in,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
`ifdef SERDES_RX_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Even parity: mismatch when data ones plus the parity bit are odd.
    function automatic logic even_parity_mismatch(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic [7:0] shift_r;
    logic [7:0] shift_nxt_s;
`ifdef SERDES_RX_PARITY_EN
    logic       par_bad_r;
    logic       par_bad_nxt_s;
`endif
    logic       frame_bad_s;
    logic       parity_bad_s;
    logic       good_s;
    logic [7:0] data_nxt_s;
    logic       valid_nxt_s;
    logic       ovr_nxt_s;

    // Frame FSM next-state, bit counter, shift register and frame verdict.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        shift_nxt_s   = shift_r;
`ifdef SERDES_RX_PARITY_EN
        par_bad_nxt_s = par_bad_r;
`endif
        frame_bad_s   = 1'b0;
        parity_bad_s  = 1'b0;
        good_s        = 1'b0;
        if (ser_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (ser_in == ~IDLE_LVL) begin
                        state_nxt_s = ST_DATA;
                        cnt_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_nxt_s[cnt_r] = ser_in;
                    cnt_nxt_s          = cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
`ifdef SERDES_RX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
`ifdef SERDES_RX_PARITY_EN
                ST_PARITY: begin
                    par_bad_nxt_s = even_parity_mismatch(shift_r, ser_in);
                    state_nxt_s   = ST_STOP;
                end
`endif
                ST_STOP: begin
                    state_nxt_s = ST_IDLE;
                    if (ser_in != IDLE_LVL) begin
                        frame_bad_s = 1'b1;
`ifdef SERDES_RX_PARITY_EN
                    end else if (par_bad_r) begin
                        parity_bad_s = 1'b1;
`endif
                    end else begin
                        good_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output buffer: load, overrun on a full buffer, and consumer reads.
    always_comb begin
        data_nxt_s  = data_out;
        valid_nxt_s = data_valid;
        ovr_nxt_s   = overrun;
        if (good_s) begin
            if (!data_valid || rd_en) begin
                data_nxt_s  = shift_r;
                valid_nxt_s = 1'b1;
                if (rd_en) begin
                    ovr_nxt_s = 1'b0;
                end else begin
                    ovr_nxt_s = overrun;
                end
            end else begin
                ovr_nxt_s = 1'b1;
            end
        end else if (rd_en) begin
            valid_nxt_s = 1'b0;
            ovr_nxt_s   = 1'b0;
        end else begin
            valid_nxt_s = data_valid;
        end
    end

    // Receiver state registers; reset aborts any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            shift_r   <= 8'h00;
`ifdef SERDES_RX_PARITY_EN
            par_bad_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shift_r   <= shift_nxt_s;
`ifdef SERDES_RX_PARITY_EN
            par_bad_r <= par_bad_nxt_s;
`endif
        end
    end

    // Registered outputs; error flags are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_out   <= data_nxt_s;
            data_valid <= valid_nxt_s;
            overrun    <= ovr_nxt_s;
            parity_err <= parity_bad_s;
            frame_err  <= frame_bad_s;
        end
    end

endmodule

// File: tb/tb_serdes_frame_rx.sv
// Testbench for serdes_frame_rx: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a frame-level model.
module tb_serdes_frame_rx;

    localparam logic IDLE = 1'b1;
`ifdef SERDES_RX_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_en;
    logic       ser_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    serdes_frame_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_en     (ser_en),
        .ser_in     (ser_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         bad_par;
        bit         bad_stop;
        bit         rd_after;
        logic [7:0] e_data;
        bit         e_valid;
        bit         e_perr;
        bit         e_ferr;
        bit         e_ovr;
    } vec_t;

    vec_t tbl[8];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check8(name, {7'd0, act}, {7'd0, exp});
    endtask

    // Drive a frame; gapped inserts a non-strobe cycle every third cycle,
    // nbits limits how many frame bits get strobed.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit gapped, input int nbits);
        logic fb[$];
        int   lim;
        int   i;
        int   c;
        fb.push_back(~IDLE);
        for (int k = 0; k < 8; k++) fb.push_back(d[k]);
`ifdef SERDES_RX_PARITY_EN
        fb.push_back((^d) ^ bad_par);
`endif
        fb.push_back(bad_stop ? ~IDLE : IDLE);
        lim = (nbits < fb.size()) ? nbits : fb.size();
        i = 0;
        c = 0;
        while (i < lim) begin
            ser_en = gapped ? ((c % 3) != 2) : 1'b1;
            ser_in = ser_en ? fb[i] : ~fb[i];
            @(posedge clk);
            #1;
            if (ser_en) i++;
            c++;
        end
        ser_en = 1'b0;
        ser_in = IDLE;
    endtask

    // Frame-level reference model: collects bits after a start bit and
    // judges the whole frame once FLEN-1 bits have arrived.
    bit         m_busy;
    bit         m_col[$];
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_perr;
    bit         m_ferr;
    bit         m_ovr;

    task automatic model_reset();
        m_busy = 0; m_col.delete(); m_data = 8'h00;
        m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit en, input bit b, input bit rd);
        bit         good;
        bit         par_ok;
        logic [7:0] byt;
        good = 0; m_perr = 0; m_ferr = 0;
        if (en) begin
            if (!m_busy) begin
                if (b != IDLE) begin
                    m_busy = 1;
                    m_col.delete();
                end
            end else begin
                m_col.push_back(b);
                if (m_col.size() == FLEN - 1) begin
                    for (int k = 0; k < 8; k++) byt[k] = m_col[k];
                    par_ok = 1;
`ifdef SERDES_RX_PARITY_EN
                    par_ok = (((^byt) ^ m_col[8]) == 1'b0);
`endif
                    if (m_col[FLEN-2] != IDLE) m_ferr = 1;
                    else if (!par_ok) m_perr = 1;
                    else good = 1;
                    m_busy = 0;
                    if (good) begin
                        if (!m_valid) begin
                            m_data = byt; m_valid = 1;
                        end else if (rd) begin
                            m_data = byt; m_ovr = 0;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            end
        end
        if (!good && rd) begin
            m_valid = 0;
            m_ovr = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ser_en = 1'b0;
        ser_in = IDLE;
        rd_en = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic bitq[$];

    initial begin
        logic [7:0] rb;
        bit         bp;
        bit         bs;

        tbl[0] = '{8'hA5, 0, 0, 1, 8'hA5, 1, 0, 0, 0};
`ifdef SERDES_RX_PARITY_EN
        tbl[1] = '{8'hA5, 1, 0, 1, 8'hA5, 0, 1, 0, 0};
`else
        tbl[1] = '{8'hA5, 1, 0, 1, 8'hA5, 1, 0, 0, 0};
`endif
        tbl[2] = '{8'h3C, 0, 1, 0, 8'hA5, 0, 0, 1, 0};
        tbl[3] = '{8'h81, 0, 0, 1, 8'h81, 1, 0, 0, 0};
        tbl[4] = '{8'h11, 0, 0, 0, 8'h11, 1, 0, 0, 0};
        tbl[5] = '{8'h22, 0, 0, 1, 8'h11, 1, 0, 0, 1};
        tbl[6] = '{8'hFF, 0, 0, 0, 8'hFF, 1, 0, 0, 0};
`ifdef SERDES_RX_PARITY_EN
        tbl[7] = '{8'h0F, 1, 0, 1, 8'hFF, 1, 1, 0, 0};
`else
        tbl[7] = '{8'h0F, 1, 0, 1, 8'hFF, 1, 0, 0, 1};
`endif

        // Reset values.
        do_reset();
        check8("reset data_out", data_out, 8'h00);
        check1("reset data_valid", data_valid, 1'b0);
        check1("reset parity_err", parity_err, 1'b0);
        check1("reset frame_err", frame_err, 1'b0);
        check1("reset overrun", overrun, 1'b0);

        // Directed vector table.
        for (int k = 0; k < 8; k++) begin
            send_frame(tbl[k].d, tbl[k].bad_par, tbl[k].bad_stop, 1'b0, 99);
            check8($sformatf("vec%0d data_out", k), data_out, tbl[k].e_data);
            check1($sformatf("vec%0d data_valid", k), data_valid, tbl[k].e_valid);
            check1($sformatf("vec%0d parity_err", k), parity_err, tbl[k].e_perr);
            check1($sformatf("vec%0d frame_err", k), frame_err, tbl[k].e_ferr);
            check1($sformatf("vec%0d overrun", k), overrun, tbl[k].e_ovr);
            rd_en = tbl[k].rd_after;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            check1($sformatf("vec%0d parity_err pulse end", k), parity_err, 1'b0);
            check1($sformatf("vec%0d frame_err pulse end", k), frame_err, 1'b0);
            if (tbl[k].rd_after) begin
                check1($sformatf("vec%0d valid after read", k), data_valid, 1'b0);
                check1($sformatf("vec%0d overrun after read", k), overrun, 1'b0);
            end
        end

        // Back-to-back frames: the second start directly follows the stop.
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 99);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 99);
        check8("b2b data_out", data_out, 8'hC3);
        check1("b2b overrun", overrun, 1'b1);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check1("b2b read clears valid", data_valid, 1'b0);

        // Strobe gaps during a full frame.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 99);
        check8("gapped data_out", data_out, 8'hA5);
        check1("gapped data_valid", data_valid, 1'b1);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;

        // Reset mid-frame, then a clean frame.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 5);
        rst_n = 1'b0;
        #1;
        check8("midreset data_out", data_out, 8'h00);
        check1("midreset data_valid", data_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 99);
        check8("after reset data_out", data_out, 8'h5A);
        check1("after reset data_valid", data_valid, 1'b1);
        check1("after reset frame_err", frame_err, 1'b0);
        check1("after reset parity_err", parity_err, 1'b0);

        // Randomized run against the frame-level model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ser_en = ($urandom_range(0, 3) != 0);
            rd_en  = ($urandom_range(0, 5) == 0);
            if (ser_en) begin
                if (bitq.size() == 0) begin
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) bitq.push_back(IDLE);
                    rb = 8'($urandom_range(0, 255));
                    bp = ($urandom_range(0, 5) == 0);
                    bs = ($urandom_range(0, 5) == 0);
                    bitq.push_back(~IDLE);
                    for (int k = 0; k < 8; k++) bitq.push_back(rb[k]);
`ifdef SERDES_RX_PARITY_EN
                    bitq.push_back((^rb) ^ bp);
`endif
                    bitq.push_back(bs ? ~IDLE : IDLE);
                end
                ser_in = bitq.pop_front();
            end else begin
                ser_in = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            model_step(ser_en, ser_in, rd_en);
            #1;
            check8("rand data_out", data_out, m_data);
            check1("rand data_valid", data_valid, m_valid);
            check1("rand parity_err", parity_err, m_perr);
            check1("rand frame_err", frame_err, m_ferr);
            check1("rand overrun", overrun, m_ovr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_frame_rx.md
# serdes_frame_rx

Framed serial receiver for the SerDes link, and the far-end counterpart of the serializer in the `tt_um_serdes` path. It samples `ser_in` on bit strobes and recognises start-bit framed words. It checks parity and stop bits, then presents each recovered byte on a parallel port that holds the byte until it is read. It sits between the serial input pad and the parallel data consumer.

## Interface
Parameters:
- `IDLE_LVL`, default 1: line level when the line is idle. The start bit is the inverse of this level; the stop bit equals it.

Ports:
- `clk` input, 1: single clock; all state changes on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `ser_en` input, 1: bit strobe. `ser_in` is sampled only on edges where `ser_en`=1.
- `ser_in` input, 1: serial line.
- `rd_en` input, 1: consumer read strobe.
- `data_out` output, 8: last accepted byte.
- `data_valid` output, 1: `data_out` holds an unread byte.
- `parity_err` output, 1: one-cycle pulse when a frame is dropped for bad parity.
- `frame_err` output, 1: one-cycle pulse when a frame is dropped for a bad stop bit.
- `overrun` output, 1: sticky flag; a good frame was dropped because the buffer was full.

## Operation
- Frame format: start bit (!IDLE_LVL), then data bits 0..7 (LSB first), then the parity bit (even parity, when configured), then the stop bit (IDLE_LVL).
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on edges with `ser_en`=1. When `ser_en`=0, all states and counters hold.
  - IDLE → DATA: the sample equals !IDLE_LVL. The 3-bit bit counter is cleared.
  - DATA: the sample is shifted into the shift register at bit position `cnt`, and `cnt` increments.
    - At `cnt`=7, the FSM goes to PARITY (parity configured) or STOP (parity not configured).
  - PARITY: the parity bit is sampled and the mismatch result is stored. Next state is STOP.
  - STOP → IDLE, always. On this sample:
    - If stop ≠ IDLE_LVL: pulse `frame_err` and discard the byte. A frame error takes priority over a parity error; only `frame_err` pulses.
    - Else if a parity mismatch was stored: pulse `parity_err` and discard the byte.
    - Else the byte is good and goes to buffer handling.
- Buffer handling for a good byte:
  - `data_valid`=0: load `data_out` and set `data_valid`.
  - `data_valid`=1 and `rd_en`=1 on the same edge: load the new byte; `data_valid` stays 1.
  - `data_valid`=1 and `rd_en`=0: drop the new byte and set `overrun`. `data_out` is unchanged.
- `rd_en` with `data_valid`=1 (no simultaneous good byte): clears `data_valid` and `overrun`.
- `rd_en` with `data_valid`=0: ignored. `overrun` is also cleared by this.
- There is no false-start filter. A start bit is qualified only by the frame checks.
- Back-to-back frames are supported: a start bit may arrive on the strobe immediately after the stop bit.

## Timing
- Reset values: FSM in IDLE, counter 0, shift register 0. `data_out`=8'h00; `data_valid`, `parity_err`, `frame_err` and `overrun` are all 0.
- Reset asserted mid-frame aborts the frame immediately; the partial byte is lost.
- Latency: `data_out` and `data_valid` update on the same edge that samples the stop bit, so they are visible in the cycle after that edge.
- `parity_err` and `frame_err` are high for exactly one clock, starting after the stop-bit edge, regardless of `ser_en` in the following cycle.
- Frame length: 11 strobes with parity, 10 without.
- All outputs are registered, with no combinational path from any input to any output.

## Configuration
- Macro: `SERDES_RX_PARITY_EN`.
- Defined: the PARITY state exists and the frame is 11 bits. `parity_err` behaves as specified above.
- Undefined: the PARITY state is removed; the FSM goes DATA → STOP and the frame is 10 bits. `parity_err` is tied to 0.

## Test plan
- With parity, IDLE_LVL=1, `ser_en`=1 every cycle: send 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0) → `data_out`=0xA5, `data_valid`=1 one cycle after the 11th edge, no error pulses.
- Same frame with the parity bit flipped to 1 → single-cycle `parity_err`; `data_valid` stays 0 and `data_out` is unchanged.
- Send 0x3C with the stop bit set to 0 → single-cycle `frame_err` only; the next frame, 0x81, is received correctly.
- Send 0x11 and 0x22 without `rd_en` → `data_out`=0x11 and `overrun`=1. Then pulse `rd_en` → `data_valid`=0 and `overrun`=0.
- Toggle `ser_en` every 3rd cycle during the 0xA5 frame, then assert `rst_n`=0 after bit 4 and resend 0x5A → the aborted frame yields nothing; 0x5A is received correctly.
- Build without `SERDES_RX_PARITY_EN`: send a 10-bit frame for 0xFF → `data_out`=0xFF, and `parity_err` stays 0 throughout.
